el2_exu_div_noc_arbiter: RTL and testbench
==========================================

Name: el2_exu_div_noc_arbiter

Overview:
- Shares one NoC-attached divider among NUM_REQ requesters (EXU divide ports).
- Grants requesters round-robin and drives operands to the NoC sender side with a valid/ready handshake.
- Waits for the result from the divider receiver, then returns it to the owner as a one-hot done pulse.
- Pulses noc_sr_flush so the serial receiver can accept the next packet; one operation is outstanding at a time.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- DATA_W, 32, operand/result width.

Ports:
- clk_noc  in  1  NoC clock.
- rst_l  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester divide request.
- req_ready  out  NUM_REQ  one-hot accept, combinational, IDLE state only.
- req_dividend  in  NUM_REQ*DATA_W  packed, requester i at [i*DATA_W +: DATA_W].
- req_divisor  in  NUM_REQ*DATA_W  packed, same layout.
- req_rem  in  NUM_REQ  1 = remainder op, 0 = quotient op.
- req_unsign  in  NUM_REQ  1 = unsigned op.
- req_cancel  in  NUM_REQ  kill this requester's pending/outstanding op.
- send_valid  out  1  operands valid toward NoC sender.
- send_ready  in  1  sender accepts.
- send_dividend, send_divisor  out  DATA_W each  latched operands.
- send_rem, send_unsign  out  1 each  latched op controls.
- rsp_valid  in  1  finish_dly from divider receiver.
- rsp_data  in  DATA_W  result from divider receiver.
- noc_sr_flush  out  1  one-cycle flush pulse to receiver.
- done_valid  out  NUM_REQ  one-hot result pulse.
- done_data  out  DATA_W  result, valid with done_valid.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: state IDLE, rr_ptr=0, killed=0. All outputs 0 (send_* data, done_data, noc_sr_flush, done_valid, busy).
- Reset asserted mid-operation: everything is abandoned immediately; no done pulse follows.
- Arbitration: eligible = req_valid & ~req_cancel. Search starts at rr_ptr, wraps at NUM_REQ-1 -> 0.
  - On grant to index g, rr_ptr <= (g+1) mod NUM_REQ.
- IDLE:
  - If any eligible: req_ready[g]=1 that cycle. Latch operands, rem, unsign and owner=g; clear killed; go SEND.
  - Otherwise stay in IDLE.
- SEND:
  - send_valid=1 with latched values.
  - Once send_valid rises, it and the data stay stable until send_ready.
  - On send_valid&send_ready go WAIT.
- WAIT:
  - On rsp_valid, capture rsp_data and go FLUSH.
- FLUSH, exactly one cycle:
  - noc_sr_flush=1.
  - done_valid[owner]=~killed, done_data=captured data; done_data holds its value afterwards.
  - Next state IDLE. The earliest next grant is the cycle after FLUSH.
- Cancel:
  - req_cancel[owner] in SEND or WAIT sets killed. The NoC transfer and response still complete, the flush is still issued, and done_valid is suppressed.
  - Cancel in the same cycle as rsp_valid also suppresses done.
  - Cancel of a non-owner has no effect on the current op.
- rsp_valid outside WAIT is ignored.
- Latency: grant T; send_valid from T+1; done at R+1 when rsp_valid is at cycle R.
- Simultaneous requests: only one grant per IDLE cycle. Losers keep req_valid asserted and are served in rotation.

Optional Feature:
- Macro: EL2_DIV_NOC_DIV0_BYPASS_EN.
- When defined, a granted op with divisor==0 skips the NoC:
  - IDLE -> BYPASS state, 1 cycle, no send_valid and no noc_sr_flush.
  - done_valid[owner]=~killed.
  - done_data = dividend for remainder ops, all-ones for quotient ops (RISC-V semantics).
  - Then IDLE.
- When not defined, divisor==0 goes through the NoC path like any other op.

Test Plan:
- Single op, no contention: req 0, dividend=100, divisor=7, rem=0; send_ready held 1; rsp_valid with 14 three cycles later -> done_valid=01, done_data=14 one cycle after rsp_valid, noc_sr_flush high that same cycle, busy low next cycle.
- Round-robin: req_valid=11 held continuously -> grants alternate 0,1,0,1; after reset, requester 0 is granted first.
- Backpressure: send_ready=0 for 5 cycles -> send_valid and operands stay stable throughout; WAIT is entered only after the handshake.
- Cancel during WAIT: cancel owner 1, then rsp_valid with 0xDEAD -> done_valid stays 00, noc_sr_flush still pulses, next request granted normally.
- Reset mid-WAIT: rst_l low for 1 cycle -> all outputs 0 and state IDLE; a later stray rsp_valid produces no done.
- With EL2_DIV_NOC_DIV0_BYPASS_EN: divisor=0, dividend=5, rem=1 -> done_data=5 at T+1, no send_valid; same with rem=0 -> done_data=0xFFFFFFFF.

Source files
------------

// File: rtl/el2_exu_div_noc_arbiter.sv
// Round-robin arbiter sharing one NoC-attached divider among NUM_REQ
// requesters. One op in flight: grant -> send -> wait -> flush -> done.
// Ports: clk_noc/rst_l; req_* per-requester inputs, req_ready one-hot accept;
// send_* operands to NoC sender; rsp_* result from receiver;
// noc_sr_flush receiver flush pulse; done_valid/done_data result; busy.
// Optional macro EL2_DIV_NOC_DIV0_BYPASS_EN: divide-by-zero answered locally.
module el2_exu_div_noc_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
) (
  input  logic                      clk_noc,
  input  logic                      rst_l,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_dividend,
  input  logic [NUM_REQ*DATA_W-1:0] req_divisor,
  input  logic [NUM_REQ-1:0]        req_rem,
  input  logic [NUM_REQ-1:0]        req_unsign,
  input  logic [NUM_REQ-1:0]        req_cancel,
  output logic                      send_valid,
  input  logic                      send_ready,
  output logic [DATA_W-1:0]         send_dividend,
  output logic [DATA_W-1:0]         send_divisor,
  output logic                      send_rem,
  output logic                      send_unsign,
  input  logic                      rsp_valid,
  input  logic [DATA_W-1:0]         rsp_data,
  output logic                      noc_sr_flush,
  output logic [NUM_REQ-1:0]        done_valid,
  output logic [DATA_W-1:0]         done_data,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_FLUSH,
    S_BYPASS
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic               killed_q, killed_d;
  logic [DATA_W-1:0]  dvd_q, dvd_d;
  logic [DATA_W-1:0]  dvs_q, dvs_d;
  logic               rem_q, rem_d;
  logic               uns_q, uns_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic [NUM_REQ-1:0] elig;
  logic               gnt_any;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   gnt_nxt;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [NUM_REQ-1:0] own_oh;
  logic [PTR_W:0]     sum;
  logic [PTR_W-1:0]   idx;
  logic [DATA_W-1:0]  sel_dvd;
  logic [DATA_W-1:0]  sel_dvs;
  logic               sel_rem;
  logic               sel_uns;

  assign elig = req_valid & ~req_cancel;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NUM_REQ))
        sum = sum - (PTR_W+1)'(NUM_REQ);
      idx = sum[PTR_W-1:0];
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    sel_dvd = '0;
    sel_dvs = '0;
    sel_rem = 1'b0;
    sel_uns = 1'b0;
    gnt_oh  = '0;
    own_oh  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        sel_dvd   = req_dividend[i*DATA_W +: DATA_W];
        sel_dvs   = req_divisor[i*DATA_W +: DATA_W];
        sel_rem   = req_rem[i];
        sel_uns   = req_unsign[i];
        gnt_oh[i] = gnt_any;
      end
      if (owner_q == PTR_W'(i))
        own_oh[i] = 1'b1;
    end
  end

  assign gnt_nxt = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    killed_d = killed_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    uns_d    = uns_q;
    data_d   = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          rr_ptr_d = gnt_nxt;
          owner_d  = gnt_idx;
          killed_d = 1'b0;
          dvd_d    = sel_dvd;
          dvs_d    = sel_dvs;
          rem_d    = sel_rem;
          uns_d    = sel_uns;
          state_d  = S_SEND;
`ifdef EL2_DIV_NOC_DIV0_BYPASS_EN
          // RISC-V div-by-zero: rem -> dividend, quotient -> all ones.
          if (sel_dvs == '0) begin
            state_d = S_BYPASS;
            data_d  = sel_rem ? sel_dvd : '1;
          end
`endif
        end
      end
      S_SEND: begin
        if (req_cancel[owner_q])
          killed_d = 1'b1;
        if (send_ready)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (req_cancel[owner_q])
          killed_d = 1'b1;
        if (rsp_valid) begin
          data_d  = rsp_data;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH:  state_d = S_IDLE;
      S_BYPASS: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_noc or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      killed_q <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= 1'b0;
      uns_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      killed_q <= killed_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      uns_q    <= uns_d;
      data_q   <= data_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE) ? gnt_oh : '0;
  assign send_valid    = (state_q == S_SEND);
  assign send_dividend = dvd_q;
  assign send_divisor  = dvs_q;
  assign send_rem      = rem_q;
  assign send_unsign   = uns_q;
  assign noc_sr_flush  = (state_q == S_FLUSH);
  assign done_valid    = ((state_q == S_FLUSH || state_q == S_BYPASS)
                          && !killed_q) ? own_oh : '0;
  assign done_data     = data_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_el2_exu_div_noc_arbiter.sv
// Directed bench for el2_exu_div_noc_arbiter with a done-result scoreboard.
// Covers reset, round-robin, backpressure, cancel, reset mid-op, div0 bypass.
module tb_el2_exu_div_noc_arbiter;

  localparam int NR = 2;
  localparam int DW = 32;

  logic           clk_noc = 1'b0;
  logic           rst_l;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [NR*DW-1:0] req_dividend;
  logic [NR*DW-1:0] req_divisor;
  logic [NR-1:0]  req_rem;
  logic [NR-1:0]  req_unsign;
  logic [NR-1:0]  req_cancel;
  logic           send_valid;
  logic           send_ready;
  logic [DW-1:0]  send_dividend;
  logic [DW-1:0]  send_divisor;
  logic           send_rem;
  logic           send_unsign;
  logic           rsp_valid;
  logic [DW-1:0]  rsp_data;
  logic           noc_sr_flush;
  logic [NR-1:0]  done_valid;
  logic [DW-1:0]  done_data;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [NR+DW-1:0] sb[$];

  el2_exu_div_noc_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk_noc(clk_noc), .rst_l(rst_l),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_rem(req_rem), .req_unsign(req_unsign), .req_cancel(req_cancel),
    .send_valid(send_valid), .send_ready(send_ready),
    .send_dividend(send_dividend), .send_divisor(send_divisor),
    .send_rem(send_rem), .send_unsign(send_unsign),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .noc_sr_flush(noc_sr_flush),
    .done_valid(done_valid), .done_data(done_data), .busy(busy)
  );

  always #5 clk_noc = ~clk_noc;

  // Every done pulse must match the oldest expected result.
  always @(negedge clk_noc) begin
    logic [NR+DW-1:0] exp;
    if (done_valid !== '0) begin
      exp = '0;
      if (sb.size() != 0) exp = sb.pop_front();
      n_cmp++;
      assert ({done_valid, done_data} === exp) else begin
        n_bad++;
        $error("FAIL done_sb: got %0h expected %0h",
               {done_valid, done_data}, exp);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_noc);
    #2;
  endtask

  // Entered in an IDLE cycle with req_valid already driven.
  // kill: 0 none, 1 cancel owner in WAIT, 2 cancel with rsp, 3 cancel other.
  task automatic run_op(input int g, input logic [DW-1:0] res,
                        input int kill, input bit hold, input int nw);
    logic [NR-1:0] oh;
    oh = '0;
    oh[g] = 1'b1;
    #1 chk("grant", req_ready, oh);
    cyc();
    if (!hold) req_valid = '0;
    #1 chk("send_v", send_valid, 1);
    chk("send_dvd", send_dividend, req_dividend[g*DW +: DW]);
    chk("send_dvs", send_divisor, req_divisor[g*DW +: DW]);
    chk("send_ctl", {send_rem, send_unsign}, {req_rem[g], req_unsign[g]});
    cyc();
    for (int k = 0; k < nw; k++) begin
      if (kill == 1 && k == 0) req_cancel = oh;
      if (kill == 3) req_cancel = ~oh;
      cyc();
      req_cancel = '0;
    end
    rsp_valid = 1'b1;
    rsp_data  = res;
    if (kill == 2) req_cancel = oh;
    if (kill == 0 || kill == 3) sb.push_back({oh, res});
    cyc();
    rsp_valid  = 1'b0;
    req_cancel = '0;
    #1 chk("flush", noc_sr_flush, 1);
    chk("done_v", done_valid, (kill == 0 || kill == 3) ? oh : '0);
    chk("done_d", done_data, res);
    cyc();
  endtask

  initial begin
    rst_l        = 1'b0;
    req_valid    = '0;
    req_dividend = {32'd1100, 32'd100};
    req_divisor  = {32'd13, 32'd7};
    req_rem      = 2'b10;
    req_unsign   = 2'b10;
    req_cancel   = '0;
    send_ready   = 1'b1;
    rsp_valid    = 1'b0;
    rsp_data     = '0;
    cyc();
    cyc();
    #1 chk("rst_busy", busy, 0);
    chk("rst_send", {send_valid, send_dividend, send_divisor}, '0);
    chk("rst_ctl", {send_rem, send_unsign, noc_sr_flush}, '0);
    chk("rst_done", {done_valid, done_data}, '0);
    rst_l = 1'b1;
    cyc();

    // Round-robin with both requesting continuously.
    req_valid = 2'b11;
    run_op(0, 32'h100, 0, 1, 1);
    run_op(1, 32'h101, 0, 1, 1);
    run_op(0, 32'h102, 0, 1, 1);
    run_op(1, 32'h103, 0, 0, 1);

    // Single op: 100 / 7.
    req_valid = 2'b01;
    run_op(0, 32'd14, 0, 0, 2);
    #1 chk("idle_busy", busy, 0);
    chk("done_hold", done_data, 32'd14);

    // Backpressure on requester 1.
    req_valid  = 2'b10;
    send_ready = 1'b0;
    #1 chk("bp_grant", req_ready, 2'b10);
    cyc();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_valid", send_valid, 1);
      chk("bp_dvd", send_dividend, 32'd1100);
      chk("bp_dvs", send_divisor, 32'd13);
      cyc();
    end
    send_ready = 1'b1;
    #1 chk("bp_hs", send_valid, 1);
    cyc();
    #1 chk("bp_wait", {send_valid, busy}, 2'b01);
    rsp_valid = 1'b1;
    rsp_data  = 32'h1234;
    sb.push_back({2'b10, 32'h1234});
    cyc();
    rsp_valid = 1'b0;
    #1 chk("bp_flush", noc_sr_flush, 1);
    cyc();

    // Cancels.
    req_valid = 2'b10;
    run_op(1, 32'hDEAD, 1, 0, 1);
    req_valid = 2'b01;
    run_op(0, 32'h42, 0, 0, 1);
    req_valid = 2'b10;
    run_op(1, 32'h99, 2, 0, 1);
    req_valid = 2'b01;
    run_op(0, 32'h55, 3, 0, 1);

    // Reset while waiting for the response.
    req_valid = 2'b10;
    #1 chk("rw_grant", req_ready, 2'b10);
    cyc();
    req_valid = '0;
    cyc();
    rst_l = 1'b0;
    #1 chk("rw_busy", busy, 0);
    chk("rw_out", {send_valid, send_dividend, done_valid, done_data}, '0);
    cyc();
    rst_l     = 1'b1;
    rsp_valid = 1'b1;
    rsp_data  = 32'h66;
    cyc();
    rsp_valid = 1'b0;
    #1 chk("rw_stray", {done_valid, noc_sr_flush, busy}, '0);
    cyc();
    req_valid = 2'b11;
    run_op(0, 32'h77, 0, 0, 1);

`ifdef EL2_DIV_NOC_DIV0_BYPASS_EN
    req_divisor[31:0]  = '0;
    req_dividend[31:0] = 32'd5;
    for (int k = 0; k < 2; k++) begin
      req_rem[0] = (k == 0);
      req_valid  = 2'b01;
      #1 chk("bz_grant", req_ready, 2'b01);
      sb.push_back({2'b01, (k == 0) ? 32'd5 : 32'hFFFF_FFFF});
      cyc();
      req_valid = '0;
      #1 chk("bz_nosend", {send_valid, noc_sr_flush}, '0);
      chk("bz_data", done_data, (k == 0) ? 32'd5 : 32'hFFFF_FFFF);
      cyc();
      #1 chk("bz_idle", busy, 0);
    end
`endif

    cyc();
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
